// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode
// stall/redirect controls, and the IF/ID outputs handed to decode.
interface fetch_stage_if #(
  parameter int AW = 16,
  parameter int IW = 16
);
  logic          stall;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          if_valid;
  logic [IW-1:0] if_instr;
  logic [3:0]    if_opcode;
  logic [AW-1:0] if_pc;
  logic [AW-1:0] if_pc_plus;

  // Fetch stage side.
  modport master (
    input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc, if_pc_plus
  );

  // Memory/decode side.
  modport slave (
    output stall, redirect, redirect_pc, imem_ack, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc, if_pc_plus
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID register and a one-entry skid
// buffer that catches the word already in flight when decode stalls.
//
//  state | meaning
//  BOOT  | one idle cycle after reset, no request
//  FETCH | requesting pc; IF/ID loads or drains normally
//  FULL  | IF/ID and skid both occupied, request suppressed
module fetch_stage #(
  parameter int             AW        = 16,
  parameter int             IW        = 16,
  parameter logic [AW-1:0]  RESET_PC  = '0,
  parameter int             PC_INC    = 2,
  parameter logic [IW-1:0]  NOP_INSTR = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_stage_if.master bus
);

  localparam logic [AW-1:0] INC = AW'(PC_INC);

  typedef enum logic [1:0] {BOOT, FETCH, FULL} fetchStateT;

  fetchStateT    state;
  logic [AW-1:0] pc;
  logic          req;
  logic          ifValid;
  logic [IW-1:0] ifInstr;
  logic [AW-1:0] ifPc;
  logic [AW-1:0] ifPcPlus;
  logic [IW-1:0] skidInstr;
  logic [AW-1:0] skidPc;
  logic          transfer;

  assign transfer = req & bus.imem_ack;

  // Sequencer: PC advance, IF/ID load/hold/bubble, skid capture and drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      req       <= 1'b0;
      ifValid   <= 1'b0;
      ifInstr   <= NOP_INSTR;
      ifPc      <= '0;
      ifPcPlus  <= INC;
      skidInstr <= NOP_INSTR;
      skidPc    <= '0;
    end else if (bus.redirect) begin
      // Flush wins over everything; a word arriving this cycle is stale.
      state   <= FETCH;
      pc      <= bus.redirect_pc;
      req     <= 1'b1;
      ifValid <= 1'b0;
      ifInstr <= NOP_INSTR;
    end else begin
      unique case (state)
        BOOT: begin
          state <= FETCH;
          req   <= 1'b1;
        end
        FETCH: begin
          if (transfer && (!ifValid || !bus.stall)) begin
            ifValid  <= 1'b1;
            ifInstr  <= bus.imem_rdata;
            ifPc     <= pc;
            ifPcPlus <= pc + INC;
            pc       <= pc + INC;
          end else if (transfer) begin
            // Decode is holding a valid word: park the new one.
            skidInstr <= bus.imem_rdata;
            skidPc    <= pc;
            pc        <= pc + INC;
            req       <= 1'b0;
            state     <= FULL;
          end else if (!bus.stall) begin
            ifValid <= 1'b0;
            ifInstr <= NOP_INSTR;
          end
        end
        FULL: begin
          if (!bus.stall) begin
            ifValid  <= 1'b1;
            ifInstr  <= skidInstr;
            ifPc     <= skidPc;
            ifPcPlus <= skidPc + INC;
            req      <= 1'b1;
            state    <= FETCH;
          end
        end
        default: begin
          state <= BOOT;
          req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.if_valid   = ifValid;
  assign bus.if_instr   = ifInstr;
  assign bus.if_opcode  = ifInstr[IW-1:IW-4];
  assign bus.if_pc      = ifPc;
  assign bus.if_pc_plus = ifPcPlus;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: every accepted fetch is queued as the
// instruction decode should later see; a negedge monitor pops and compares.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] salt = 16'hA000;

  fetch_stage_if #(.AW(16), .IW(16)) bus ();

  fetch_stage #(
    .AW(16), .IW(16), .RESET_PC(16'h0000), .PC_INC(2), .NOP_INSTR(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory returns a word derived from the requested address.
  assign bus.imem_rdata = bus.imem_addr ^ salt;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } entT;

  entT         q[$];
  logic [15:0] modelPc;
  int          cyc;
  bit          rstSeen;
  int          nVec;
  int          nErr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model and monitor, evaluated mid-cycle with inputs stable.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      modelPc = 16'h0000;
      cyc     = 0;
      rstSeen = 1'b1;
    end else if (rstSeen) begin
      automatic int  qs = q.size();
      automatic bit  expReq = (cyc >= 1) && (qs < 2);
      if (cyc == 0) begin
        chk("rst_if_pc", bus.if_pc, 16'h0000);
        chk("rst_if_pc_plus", bus.if_pc_plus, 16'h0002);
        chk("rst_addr", bus.imem_addr, 16'h0000);
      end
      chk("if_valid", bus.if_valid, qs != 0);
      chk("imem_req", bus.imem_req, expReq);
      if (bus.imem_req) chk("imem_addr", bus.imem_addr, modelPc);
      if (qs != 0) begin
        chk("if_instr", bus.if_instr, q[0].instr);
        chk("if_pc", bus.if_pc, q[0].pc);
        chk("if_pc_plus", bus.if_pc_plus, 16'(q[0].pc + 16'd2));
        chk("if_opcode", bus.if_opcode, q[0].instr[15:12]);
        if (!bus.stall) void'(q.pop_front());
      end else begin
        chk("bubble_instr", bus.if_instr, 16'h0000);
        chk("bubble_opcode", bus.if_opcode, 4'h0);
      end
      if (bus.redirect) begin
        q.delete();
        modelPc = bus.redirect_pc;
      end else if (bus.imem_req && bus.imem_ack) begin
        q.push_back('{instr: bus.imem_rdata, pc: modelPc});
        modelPc = modelPc + 16'd2;
      end
      cyc++;
    end
  end

  task automatic step(input logic s, input logic a, input logic r, input logic [15:0] rp);
    @(posedge clk);
    #1;
    bus.stall       = s;
    bus.imem_ack    = a;
    bus.redirect    = r;
    bus.redirect_pc = rp;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
  endtask

  // Stimulus: directed scenarios, then randomized traffic with rare resets.
  initial begin
    nVec = 0;
    nErr = 0;
    rstSeen = 1'b0;
    bus.stall = 1'b0;
    bus.imem_ack = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(8);
    // Stall across a live fetch, then release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    idle(4);
    // Redirect with a coincident transfer.
    step(1'b0, 1'b1, 1'b1, 16'h0040);
    idle(4);
    // Reach FULL, then redirect while stalled.
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'h0080);
    idle(4);
    // Memory not acknowledging for three cycles.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
    idle(3);
    // Address wrap at the top of memory.
    step(1'b0, 1'b1, 1'b1, 16'hFFFC);
    idle(4);
    // Reset while FULL.
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      automatic logic [15:0] rp = ($urandom_range(0, 2) == 0) ?
                                  (16'hFFF0 | (16'($urandom) & 16'h000E)) :
                                  (16'($urandom) & 16'hFFFE);
      salt = 16'($urandom);
      step($urandom_range(0, 9) < 3, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, rp);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
    end
    idle(4);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
